uart_baud_gen_frac: RTL and testbench

//  Parametrised fractional baud tick generator for the UART RX/TX paths.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_frac_acc.sv | 29 ++
 rtl/uart_baud_gen_frac.sv | 96 +++++++++
 tb/tb_uart_baud_gen_frac.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART baud generator slice.
// Build option UART_BAUD_FRAC_EN enables the fractional divisor.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DIV_W_DEF      = 16;
   localparam int FRAC_W_DEF     = 4;

   typedef struct packed {
      logic [DIV_W_DEF-1:0]  int_part;
      logic [FRAC_W_DEF-1:0] frac_part;
   } baud_div_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional phase accumulator; carry is the overflow the next step would produce,
// so the period in which the sum wraps is the one stretched by a cycle.
module uart_baud_frac_acc
   import uart_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              clr,
   input  logic [FRAC_W-1:0] frac,
   output logic              carry
);

   logic [FRAC_W-1:0] frac_acc;
   logic [FRAC_W:0]   sum;

   assign sum   = {1'b0, frac_acc} + {1'b0, frac};
   assign carry = sum[FRAC_W];

   always_ff @(posedge clk) begin
      if (rst || clr)
         frac_acc <= '0;
      else if (step)
         frac_acc <= sum[FRAC_W-1:0];
   end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud tick generator: oversample tick plus bit tick every OVERSAMPLE ticks.
// Define UART_BAUD_FRAC_EN to include the fractional accumulator; otherwise div_frac is ignored.
module uart_baud_gen_frac
   import uart_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int FRAC_W      = FRAC_W_DEF,
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int RST_DIV_INT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   output logic              div_pend,
   input  logic              sync_clr,
   output logic              tick_os,
   output logic              tick_bit
);

   localparam int OS_W  = cnt_w(OVERSAMPLE);
   localparam int LIM_W = DIV_W + 1;

   logic [DIV_W-1:0]  int_act, int_shd;
   logic [FRAC_W-1:0] frac_act, frac_shd;
   logic [LIM_W-1:0]  cyc_cnt, lim;
   logic [OS_W-1:0]   os_cnt;
   logic              carry, boundary, apply, os_last;

`ifdef UART_BAUD_FRAC_EN
   uart_baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
      .clk   (clk),
      .rst   (rst),
      .step  (boundary),
      .clr   (sync_clr),
      .frac  (frac_act),
      .carry (carry)
   );
`else
   logic unused_frac;
   assign carry       = 1'b0;
   assign unused_frac = ^frac_act;
`endif

   // lim is one bit wider than the divisor so all-ones plus carry cannot wrap.
   assign lim      = {1'b0, int_act} + LIM_W'(carry);
   assign boundary = en && !sync_clr && (cyc_cnt == lim);
   assign apply    = sync_clr || boundary;
   assign os_last  = (os_cnt == OS_W'(OVERSAMPLE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt  <= '0;
         os_cnt   <= '0;
         tick_os  <= 1'b0;
         tick_bit <= 1'b0;
         div_pend <= 1'b0;
         int_act  <= DIV_W'(RST_DIV_INT);
         frac_act <= '0;
         int_shd  <= '0;
         frac_shd <= '0;
      end else begin
         tick_os  <= boundary;
         tick_bit <= boundary && os_last;

         if (div_load) begin
            int_shd  <= div_int;
            frac_shd <= div_frac;
         end

         // Shadow only lands on a period boundary or a phase realign, never mid-period.
         if (apply && div_pend) begin
            int_act  <= int_shd;
            frac_act <= frac_shd;
         end

         if (div_load)
            div_pend <= 1'b1;
         else if (apply)
            div_pend <= 1'b0;

         if (sync_clr) begin
            cyc_cnt <= '0;
            os_cnt  <= '0;
         end else if (boundary) begin
            cyc_cnt <= '0;
            os_cnt  <= os_last ? '0 : os_cnt + OS_W'(1);
         end else if (en) begin
            cyc_cnt <= cyc_cnt + LIM_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac; expected tick cycles are queued by the stimulus
// and consumed by an independent monitor. Expectations follow UART_BAUD_FRAC_EN.
module tb_uart_baud_gen_frac;
   import uart_pkg::*;

   localparam int DW = DIV_W_DEF;
   localparam int FW = FRAC_W_DEF;

   logic          clk = 1'b0;
   logic          rst, en, div_load, sync_clr;
   logic          div_pend, tick_os, tick_bit;
   logic [DW-1:0] div_int;
   logic [FW-1:0] div_frac;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int c;
      bit b;
   } exp_t;

   exp_t q[$];

   uart_baud_gen_frac #(
      .DIV_W       (DW),
      .FRAC_W      (FW),
      .OVERSAMPLE  (OVERSAMPLE_DEF),
      .RST_DIV_INT (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_int  (div_int),
      .div_frac (div_frac),
      .div_load (div_load),
      .div_pend (div_pend),
      .sync_clr (sync_clr),
      .tick_os  (tick_os),
      .tick_bit (tick_bit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input bit b);
      exp_t e;
      e.c = c;
      e.b = b;
      q.push_back(e);
   endtask

   task automatic drive_div(input baud_div_t d);
      div_int  = d.int_part;
      div_frac = d.frac_part;
      div_load = 1'b1;
   endtask

   // Monitor: every tick_os must match the head of the expectation queue.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c < cyc) begin
         total++;
         bad++;
         $display("FAIL missing_tick: none at cycle %0d (now %0d)", q[0].c, cyc);
         void'(q.pop_front());
      end
      if (tick_os === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tick at cycle %0d (tick_bit=%0b)", cyc, tick_bit);
         end else begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.c != cyc || e.b !== tick_bit) begin
               bad++;
               $display("FAIL tick: got cycle %0d bit %0b expected cycle %0d bit %0b",
                        cyc, tick_bit, e.c, e.b);
            end
         end
      end else if (tick_bit === 1'b1) begin
         total++;
         bad++;
         $display("FAIL bit_without_os at cycle %0d", cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, c, d, t, r, s2, last;
      baud_div_t dv;

      rst = 1'b1; en = 1'b0; div_load = 1'b0; sync_clr = 1'b0;
      div_int = '0; div_frac = '0;

      // Reset values
      at(3);
      chk("rst_tick_os", tick_os, 0);
      chk("rst_tick_bit", tick_bit, 0);
      chk("rst_div_pend", div_pend, 0);
      rst = 1'b0;

      // Test 1: div 3, frac 0, load then realign -> tick every 4, bit every 64
      at(4);
      dv.int_part = 16'd3; dv.frac_part = 4'd0;
      drive_div(dv);
      at(5);
      chk("load_pend", div_pend, 1);
      div_load = 1'b0; sync_clr = 1'b1; en = 1'b1;
      s = 6;
      at(s);
      chk("clr_applies_pend", div_pend, 0);
      sync_clr = 1'b0;
      for (int k = 1; k <= 23; k++) push(s + 4*k, k == 16);

      // Test 4: realign on what would be the tick edge, with os_cnt at 7
      at(s + 95);
      sync_clr = 1'b1;
      c = s + 96;
      at(c);
      chk("clr_suppress_tick", tick_os, 0);
      sync_clr = 1'b0;
      for (int k = 1; k <= 16; k++) push(c + 4*k, k == 16);

      // Test 5: 7 frozen cycles mid-period
      d = c + 64;
      at(d + 2);
      en = 1'b0;
      at(d + 4);
      chk("frozen_no_tick", tick_os, 0);
      at(d + 9);
      en = 1'b1;
      push(d + 11, 1'b0);
      push(d + 15, 1'b0);
      push(d + 19, 1'b0);

      // Test 3: load div 9 at cycle 2 of a 4-cycle period
      t = d + 19;
      at(t + 1);
      dv.int_part = 16'd9; dv.frac_part = 4'd0;
      drive_div(dv);
      at(t + 2);
      div_load = 1'b0;
      chk("midperiod_pend_a", div_pend, 1);
      push(t + 4, 1'b0);
      push(t + 14, 1'b0);
      push(t + 24, 1'b0);
      at(t + 3);
      chk("midperiod_pend_b", div_pend, 1);
      at(t + 4);
      chk("boundary_clears_pend", div_pend, 0);

      // Test 6: reset on the edge that would have produced a tick, with a load pending
      at(t + 29);
      dv.int_part = 16'd5; dv.frac_part = 4'd0;
      drive_div(dv);
      at(t + 30);
      div_load = 1'b0;
      chk("pre_rst_pend", div_pend, 1);
      at(t + 33);
      rst = 1'b1; en = 1'b0;
      at(t + 34);
      chk("midrst_tick_os", tick_os, 0);
      chk("midrst_tick_bit", tick_bit, 0);
      chk("midrst_div_pend", div_pend, 0);
      rst = 1'b0;

      // Test 2: div 3, frac 8
      r = t + 34;
      at(r + 1);
      dv.int_part = 16'd3; dv.frac_part = 4'd8;
      drive_div(dv);
      at(r + 2);
      div_load = 1'b0; sync_clr = 1'b1; en = 1'b1;
      s2 = r + 3;
      at(s2);
      sync_clr = 1'b0;
`ifdef UART_BAUD_FRAC_EN
      // Periods alternate 4,5: 32 ticks land exactly 144 cycles after the realign.
      for (int n = 1; n <= 32; n++)
         push(s2 + ((n % 2 == 0) ? 9*(n/2) : 9*(n/2) + 4), (n % 16) == 0);
      last = 144;
`else
      for (int n = 1; n <= 32; n++) push(s2 + 4*n, (n % 16) == 0);
      last = 128;
`endif
      at(s2 + last);
      en = 1'b0;
      at(s2 + last + 20);
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
